// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first, with a start/busy/done handshake.
// Operands and carry-in are captured when start is accepted in IDLE; sum and cout update once per operation.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_s;
    logic             bit_c;
    logic             last_bit;
    logic [WIDTH-1:0] psum_shifted;

    // Full-adder slice on the operand LSBs and the running carry.
    always_comb begin
        bit_s        = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c        = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        psum_shifted = {bit_s, psum_q[WIDTH-1:1]};
        last_bit     = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                psum_d  = psum_shifted;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // The final bit is folded in on the same edge that publishes the result.
                    sum_d   = psum_shifted;
                    cout_d  = bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder at WIDTH=8: result values, handshake timing,
// start-ignore while busy, and reset behaviour.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge. Returns at the negedge after the done cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec, input int inject);
        int lat;
        int busy_n;
        bit held_ok;
        bit seen;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
        lat = 0; busy_n = 0; held_ok = 1'b1; seen = 1'b0;
        while (lat < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (sum !== prev_sum || cout !== prev_cout) held_ok = 1'b0;
            if (lat == inject) begin
                start = 1'b1;
                a     = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(W));
        chk("busy_cycles", 32'(busy_n), 32'(W));
        chk("held_during_shift", 32'(held_ok), 32'd1);
        chk("sum", 32'(sum), 32'(es));
        chk("cout", 32'(cout), 32'(ec));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        prev_sum  = es;
        prev_cout = ec;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rexp;
        int         extra_done;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h5A, 8'h25, 1'b1, 8'h80, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[8] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};
        vecs[9] = '{8'h01, 8'hFE, 1'b1, 8'h00, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, -1);

        // start pulsed mid-SHIFT must be ignored and produce no second done
        run_op(8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, 3);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) extra_done++;
            @(negedge clk);
        end
        chk("no_second_done", 32'(extra_done), 32'd0);
        chk("result_kept", 32'({cout, sum}), 32'h080);

        // reset while bit 4 is being processed
        a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) extra_done++;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(extra_done), 32'd0);
        prev_sum = '0; prev_cout = 1'b0;
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, -1);

        // reset wins over start on the same edge
        rst_n = 1'b0; start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_idle", 32'(busy), 32'd0);
        prev_sum = '0; prev_cout = 1'b0;

        // random back-to-back operations
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_op(ra, rb, rc, rexp[7:0], rexp[8], -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
